// File: rtl/cordic_result_fifo_pkg.sv
// Shared definitions for the CORDIC result path: word widths and the
// {flip, sin, cos} entry layout used by the FIFO, cordic_top and the consumer.
package cordic_result_fifo_pkg;

    localparam int CORDIC_WIDTH  = 16;
    localparam int CORDIC_FLIP_W = 3;

    function automatic int entry_w(input int width, input int flip_w);
        return 2 * width + flip_w;
    endfunction

    // cos occupies the LSBs, then sin, then the flip code on top
    function automatic int cos_lsb(input int width);
        return 0 * width;
    endfunction

    function automatic int sin_lsb(input int width);
        return width;
    endfunction

    function automatic int flip_lsb(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/cordic_result_fifo_fifo_ram.sv
// Register-array storage for the result FIFO: one synchronous write port and
// one asynchronous read port. Contents are deliberately not reset.
module fifo_ram
    import cordic_result_fifo_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int ENTRY_W = entry_w(CORDIC_WIDTH, CORDIC_FLIP_W),
    parameter int AW      = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               i_we,
    input  logic [AW-1:0]      i_waddr,
    input  logic [ENTRY_W-1:0] i_wdata,
    input  logic [AW-1:0]      i_raddr,
    output logic [ENTRY_W-1:0] o_rdata
);

    logic [ENTRY_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/cordic_result_fifo.sv
// Buffers CORDIC results for a valid/ready consumer. The CORDIC cannot stall,
// so a result arriving while full is dropped and counted.
module cordic_result_fifo
    import cordic_result_fifo_pkg::*;
#(
    parameter int WIDTH  = CORDIC_WIDTH,
    parameter int FLIP_W = CORDIC_FLIP_W,
    parameter int DEPTH  = 8,
    parameter int DROP_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          in_cos,
    input  logic [WIDTH-1:0]          in_sin,
    input  logic [FLIP_W-1:0]         in_flip,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [2*WIDTH+FLIP_W-1:0] out_data,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                      full,
    output logic                      overflow,
    output logic [DROP_W-1:0]         drop_cnt,
    input  logic                      clr_ovf
);

    localparam int EW       = entry_w(WIDTH, FLIP_W);
    localparam int AW       = $clog2(DEPTH);
    localparam int LW       = $clog2(DEPTH + 1);
    localparam int COS_LSB  = cos_lsb(WIDTH);
    localparam int SIN_LSB  = sin_lsb(WIDTH);
    localparam int FLIP_LSB = flip_lsb(WIDTH);

    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [LW-1:0]     r_level;
    logic              r_overflow;
    logic [DROP_W-1:0] r_drop_cnt;

    logic              w_valid;
    logic              w_full;
    logic              w_pop;
    logic              w_write;
    logic              w_drop;
    logic [EW-1:0]     w_wdata;
    logic [EW-1:0]     w_rdata;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + DROP_W'(1);
    endfunction

    always_comb begin
        w_wdata = '0;
        w_wdata[COS_LSB  +: WIDTH]  = in_cos;
        w_wdata[SIN_LSB  +: WIDTH]  = in_sin;
        w_wdata[FLIP_LSB +: FLIP_W] = in_flip;
    end

    assign w_valid = (r_level != '0);
    assign w_full  = (r_level == LW'(DEPTH));
    assign w_pop   = w_valid && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept
    assign w_write = in_valid && (!w_full || w_pop);
    assign w_drop  = in_valid && w_full && !w_pop;

    fifo_ram #(
        .DEPTH   (DEPTH),
        .ENTRY_W (EW),
        .AW      (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_write),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wdata),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_level <= r_level + LW'(w_write) - LW'(w_pop);
        end
    end

    // A drop in the same cycle as clr_ovf wins: the flag stays set, count restarts at 1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            r_drop_cnt <= clr_ovf ? DROP_W'(1) : sat_inc(r_drop_cnt);
        end else if (clr_ovf) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end
    end

    assign out_valid = w_valid;
    assign out_data  = w_valid ? w_rdata : '0;
    assign level     = r_level;
    assign full      = w_full;
    assign overflow  = r_overflow;
    assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_cordic_result_fifo.sv
// Scoreboard bench for cordic_result_fifo: the driver pushes accepted entries,
// a negedge monitor pops and compares them on each consumer handshake.
`timescale 1ns/100ps
module tb_cordic_result_fifo;

    localparam int W  = 16;
    localparam int F  = 3;
    localparam int D  = 8;
    localparam int DW = 8;
    localparam int EW = 2 * W + F;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_cos = '0;
    logic [W-1:0]  in_sin = '0;
    logic [F-1:0]  in_flip = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [EW-1:0] out_data;
    logic [3:0]    level;
    logic          full;
    logic          overflow;
    logic [DW-1:0] drop_cnt;
    logic          clr_ovf = 1'b0;

    cordic_result_fifo #(.WIDTH(W), .FLIP_W(F), .DEPTH(D), .DROP_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_cos    (in_cos),
        .in_sin    (in_sin),
        .in_flip   (in_flip),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level),
        .full      (full),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt),
        .clr_ovf   (clr_ovf)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [EW-1:0] sb[$];
    int            m_level = 0;
    logic          m_ovf   = 1'b0;
    int            m_drops = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Consumer-side monitor: handshake pops, stable head while stalled, zero when empty
    always @(negedge clk) begin
        if (rst) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 64'(out_valid), 64'd0);
                end else if (out_ready) begin
                    chk("pop_data", 64'(out_data), 64'(sb.pop_front()));
                end else begin
                    chk("hold_data", 64'(out_data), 64'(sb[0]));
                end
            end else begin
                chk("idle_data", 64'(out_data), 64'd0);
            end
        end
    end

    // Called 1 ns after a rising edge: checks state, drives one cycle, advances the model
    task automatic step(input logic v, input logic [W-1:0] c, input logic [W-1:0] s,
                        input logic [F-1:0] f, input logic rdy, input logic clr);
        bit pop, wr, drop;
        chk("level", 64'(level), 64'(m_level));
        chk("full", 64'(full), 64'(m_level == D));
        chk("out_valid", 64'(out_valid), 64'(m_level != 0));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("drop_cnt", 64'(drop_cnt), 64'(m_drops));
        in_valid  = v;
        in_cos    = c;
        in_sin    = s;
        in_flip   = f;
        out_ready = rdy;
        clr_ovf   = clr;
        pop  = (m_level > 0) && rdy;
        wr   = v && ((m_level < D) || pop);
        drop = v && !wr;
        if (wr) sb.push_back({f, s, c});
        m_level = m_level + int'(wr) - int'(pop);
        if (drop) begin
            m_ovf   = 1'b1;
            m_drops = clr ? 1 : ((m_drops + 1 > 255) ? 255 : m_drops + 1);
        end else if (clr) begin
            m_ovf   = 1'b0;
            m_drops = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_write(input logic rdy);
        step(1'b1, W'($urandom), W'($urandom), F'($urandom), rdy, 1'b0);
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && m_level > 0; k++) begin
            step(1'b0, '0, '0, '0, 1'b1, 1'b0);
        end
        chk("drain_done", 64'(m_level), 64'd0);
        step(1'b0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: sim time expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values while rst is held low
        #2;
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_drops", 64'(drop_cnt), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single pass with known words
        step(1'b1, 16'h3C00, 16'h0000, 3'b001, 1'b0, 1'b0);
        chk("single_data", 64'(out_data), 64'h1_0000_3C00);
        step(1'b0, '0, '0, '0, 1'b0, 1'b0);
        step(1'b0, '0, '0, '0, 1'b1, 1'b0);
        step(1'b0, '0, '0, '0, 1'b0, 1'b0);

        // Fill to full, one drop, drain in order
        for (int i = 0; i < D; i++) rnd_write(1'b0);
        rnd_write(1'b0);
        drain();

        // Mid-stream reset with entries held and overflow set
        for (int i = 0; i < 3; i++) rnd_write(1'b0);
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_level", 64'(level), 64'd0);
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_data", 64'(out_data), 64'd0);
        chk("midrst_ovf", 64'(overflow), 64'd0);
        chk("midrst_drops", 64'(drop_cnt), 64'd0);
        rst = 1'b1;
        sb.delete();
        m_level = 0;
        m_ovf   = 1'b0;
        m_drops = 0;
        @(posedge clk);
        #1;
        step(1'b0, '0, '0, '0, 1'b1, 1'b0);

        // Full with simultaneous write and pop
        for (int i = 0; i < D; i++) rnd_write(1'b0);
        rnd_write(1'b1);
        rnd_write(1'b1);
        step(1'b0, '0, '0, '0, 1'b0, 1'b0);
        drain();

        // Pointer wrap with 50% ready, then a fully random phase
        for (int i = 0; i < 20; i++) rnd_write(1'($urandom_range(0, 1)));
        drain();
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), W'($urandom), W'($urandom), F'($urandom),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0));
        end
        drain();
        step(1'b0, '0, '0, '0, 1'b0, 1'b1);

        // Saturation, clear racing a drop, then a plain clear
        for (int i = 0; i < D; i++) rnd_write(1'b0);
        for (int i = 0; i < 300; i++) rnd_write(1'b0);
        step(1'b1, 16'h1234, 16'h5678, 3'b101, 1'b0, 1'b1);
        step(1'b0, '0, '0, '0, 1'b0, 1'b1);
        step(1'b0, '0, '0, '0, 1'b0, 1'b0);
        drain();

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
